if_fetch_unit: RTL
==================

Name: if_fetch_unit

Overview:
Instruction-fetch stage; the producer side of the IF/ID pipeline register. It owns the PC, issues requests to instruction memory over a req/ready handshake with variable latency, and presents {pc_out, instruction_out, valid_out} to the IF/ID register. It honours the same freeze (hazard stall) and branch redirect signals that the IF/ID register sees, so no instruction is lost or duplicated.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
PC_STEP, 4, byte increment between sequential fetches

Ports:
clk  input  1  clock; all state updates on posedge
rst  input  1  synchronous, active-high reset
freeze  input  1  downstream stall; output registers hold
branch_taken  input  1  redirect request from EXE; also flushes the current output
branch_addr  input  32  redirect target
imem_req  output  1  fetch request valid
imem_addr  output  32  fetch address
imem_ready  input  1  memory accepts the request and returns data this cycle
imem_rdata  input  32  instruction word; valid when imem_req && imem_ready
pc_out  output  32  fetched address + PC_STEP
instruction_out  output  32  fetched instruction
valid_out  output  1  pc_out/instruction_out hold a real instruction (0 = bubble)

Behaviour:
- Reset (rst=1 at posedge): pc<=RESET_PC; state<=FETCH; pc_out, instruction_out, valid_out <= 0; buffer and target registers <= 0. Reset overrides every other input, including mid-handshake.
- Output registers load only when freeze=0, except that branch_taken=1 forces valid_out<=0 regardless of freeze. Flush beats freeze.
- "Accept" means imem_req && imem_ready in a cycle. Latency is 0..N cycles; imem_addr stays stable while imem_req=1 and ready=0.
- State FETCH: imem_req=1, imem_addr=pc.
  - accept & branch_taken: discard rdata; pc<=branch_addr; stay in FETCH.
  - accept & ~freeze: outputs<={pc+PC_STEP, rdata, 1}; pc<=pc+PC_STEP.
  - accept & freeze: buffer<={pc+PC_STEP, rdata}; pc<=pc+PC_STEP; go to HOLD.
  - no accept & branch_taken: target<=branch_addr; go to DRAIN.
  - no accept & ~freeze: valid_out<=0 (bubble).
- State HOLD: imem_req=0.
  - branch_taken: drop the buffer; pc<=branch_addr; go to FETCH.
  - else ~freeze: outputs<={buffer, 1}; go to FETCH.
  - else (freeze): stay in HOLD.
- State DRAIN: imem_req=1, imem_addr = old pc. The in-flight request completes and is never abandoned.
  - branch_taken: target<=branch_addr (newest wins).
  - accept: discard rdata; pc<=target (or branch_addr if branch_taken is also 1 this cycle); go to FETCH.
  - ~freeze: valid_out<=0.
- PC arithmetic is 32-bit modulo: 0xFFFF_FFFC + 4 wraps to 0.
- One instruction is delivered at most once per cycle. Every accepted non-squashed word appears on the outputs exactly once, with valid_out=1.

Optional Feature:
IF_PERF_CNT_EN
- Defined: adds outputs fetch_cnt[31:0] and squash_cnt[31:0], both reset to 0.
  - fetch_cnt increments on each word delivered with valid_out=1.
  - squash_cnt increments on each accepted word discarded and on each HOLD buffer dropped.
  - Both counters wrap.
- Undefined: these ports and registers are absent; behaviour is otherwise identical.

Decomposition:
- Shared package: fetch state enum (FETCH, HOLD, DRAIN), RESET_PC default, PC_STEP default, NOP instruction constant (32'hE1A0_0000) for bench use.
- One sub-module is natural: if_pc_reg. It holds the PC register with synchronous reset, load, and increment inputs. The FSM, buffer, and output registers stay in if_fetch_unit.

Test Plan:
- Zero-latency sequential fetch: imem_ready=1, rdata=addr^0xA5A5A5A5, no stall → imem_addr 0,4,8,…; pc_out 4,8,12,… one cycle later; valid_out=1 each cycle.
- Wait states: imem_ready low for 3 cycles at addr 0x8 → imem_addr held at 0x8; valid_out=0 for 3 cycles; then pc_out=0xC with the correct word.
- Freeze on accept: freeze=1 for 2 cycles as word@0x10 is accepted → outputs unchanged while frozen, imem_req=0; after release, pc_out=0x14 with word@0x10 delivered once.
- Branch while waiting: ready=0 at 0x20, branch_taken to 0x100 → DRAIN; next accept discarded; following imem_addr=0x100; valid_out=0 until word@0x100 arrives; squash_cnt=1 if IF_PERF_CNT_EN is defined.
- Branch plus freeze simultaneously in HOLD → valid_out=0, buffer dropped, next imem_addr=branch_addr.
- Sync reset mid-DRAIN: rst=1 for one cycle → next cycle imem_addr=RESET_PC, all outputs 0, state FETCH; wrap check: pc=0xFFFF_FFFC → next imem_addr=0x0.

Source files
------------

// File: rtl/if_fetch_unit_pkg.sv
// Shared types and defaults for the instruction-fetch stage.
package if_fetch_unit_pkg;

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      HOLD  = 2'd1,
      DRAIN = 2'd2
   } fetch_state_e;

   localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
   localparam int unsigned PC_STEP_DEF  = 4;
   localparam logic [31:0] NOP_INSTR    = 32'hE1A0_0000;

   // Modulo-2^32 PC advance.
   function automatic logic [31:0] pc_add(input logic [31:0] pc, input logic [31:0] step);
      return pc + step;
   endfunction

endpackage

// File: rtl/if_pc_reg.sv
// Program counter register: synchronous reset, absolute load (priority) or sequential increment.
module if_pc_reg
   import if_fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEF,
   parameter int unsigned PC_STEP  = PC_STEP_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic [31:0] load_addr,
   input  logic        inc,
   output logic [31:0] pc
);

   logic [31:0] pc_q, pc_d;

   always_comb begin
      pc_d = pc_q;
      if (load)
         pc_d = load_addr;
      else if (inc)
         pc_d = pc_add(pc_q, PC_STEP);
   end

   always_ff @(posedge clk) begin
      if (rst) pc_q <= RESET_PC;
      else     pc_q <= pc_d;
   end

   assign pc = pc_q;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage feeding the IF/ID register; honours freeze and branch redirect.
// Optional IF_PERF_CNT_EN adds fetch_cnt / squash_cnt counters.
module if_fetch_unit
   import if_fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEF,
   parameter int unsigned PC_STEP  = PC_STEP_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        freeze,
   input  logic        branch_taken,
   input  logic [31:0] branch_addr,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
`ifdef IF_PERF_CNT_EN
   output logic [31:0] fetch_cnt,
   output logic [31:0] squash_cnt,
`endif
   output logic [31:0] pc_out,
   output logic [31:0] instruction_out,
   output logic        valid_out
);

   fetch_state_e state_q, state_d;
   logic [31:0]  pc_out_q, pc_out_d;
   logic [31:0]  instr_q, instr_d;
   logic         valid_q, valid_d;
   logic [31:0]  buf_pc_q, buf_pc_d;
   logic [31:0]  buf_instr_q, buf_instr_d;
   logic [31:0]  tgt_q, tgt_d;

   logic        pc_load, pc_inc;
   logic [31:0] pc_load_addr;
   logic [31:0] pc;
   logic [31:0] seq_pc;
   logic        accept;

   if_pc_reg #(
      .RESET_PC (RESET_PC),
      .PC_STEP  (PC_STEP)
   ) u_pc (
      .clk       (clk),
      .rst       (rst),
      .load      (pc_load),
      .load_addr (pc_load_addr),
      .inc       (pc_inc),
      .pc        (pc)
   );

   // DRAIN keeps the request up at the old PC until memory completes it.
   assign imem_req  = (state_q != HOLD);
   assign imem_addr = pc;
   assign accept    = imem_req && imem_ready;
   assign seq_pc    = pc_add(pc, PC_STEP);

   always_comb begin
      state_d      = state_q;
      pc_out_d     = pc_out_q;
      instr_d      = instr_q;
      valid_d      = valid_q;
      buf_pc_d     = buf_pc_q;
      buf_instr_d  = buf_instr_q;
      tgt_d        = tgt_q;
      pc_load      = 1'b0;
      pc_load_addr = branch_addr;
      pc_inc       = 1'b0;

      unique case (state_q)
         FETCH: begin
            if (accept && branch_taken) begin
               pc_load = 1'b1;
            end else if (accept && !freeze) begin
               pc_out_d = seq_pc;
               instr_d  = imem_rdata;
               valid_d  = 1'b1;
               pc_inc   = 1'b1;
            end else if (accept) begin
               buf_pc_d    = seq_pc;
               buf_instr_d = imem_rdata;
               pc_inc      = 1'b1;
               state_d     = HOLD;
            end else if (branch_taken) begin
               tgt_d   = branch_addr;
               state_d = DRAIN;
            end else if (!freeze) begin
               valid_d = 1'b0;
            end
         end
         HOLD: begin
            if (branch_taken) begin
               pc_load = 1'b1;
               state_d = FETCH;
            end else if (!freeze) begin
               pc_out_d = buf_pc_q;
               instr_d  = buf_instr_q;
               valid_d  = 1'b1;
               state_d  = FETCH;
            end
         end
         DRAIN: begin
            if (branch_taken) tgt_d = branch_addr;
            if (accept) begin
               pc_load      = 1'b1;
               pc_load_addr = tgt_d;
               state_d      = FETCH;
            end
            if (!freeze) valid_d = 1'b0;
         end
         default: state_d = FETCH;
      endcase

      // Flush wins over freeze.
      if (branch_taken) valid_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= FETCH;
         pc_out_q    <= '0;
         instr_q     <= '0;
         valid_q     <= 1'b0;
         buf_pc_q    <= '0;
         buf_instr_q <= '0;
         tgt_q       <= '0;
      end else begin
         state_q     <= state_d;
         pc_out_q    <= pc_out_d;
         instr_q     <= instr_d;
         valid_q     <= valid_d;
         buf_pc_q    <= buf_pc_d;
         buf_instr_q <= buf_instr_d;
         tgt_q       <= tgt_d;
      end
   end

   assign pc_out          = pc_out_q;
   assign instruction_out = instr_q;
   assign valid_out       = valid_q;

`ifdef IF_PERF_CNT_EN
   logic [31:0] fetch_cnt_q, fetch_cnt_d;
   logic [31:0] squash_cnt_q, squash_cnt_d;
   logic        deliver, squash;

   assign deliver = !branch_taken && !freeze &&
                    ((state_q == FETCH && accept) || state_q == HOLD);
   assign squash  = (state_q == FETCH && accept && branch_taken) ||
                    (state_q == HOLD && branch_taken) ||
                    (state_q == DRAIN && accept);

   always_comb begin
      fetch_cnt_d  = fetch_cnt_q + {31'd0, deliver};
      squash_cnt_d = squash_cnt_q + {31'd0, squash};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_cnt_q  <= '0;
         squash_cnt_q <= '0;
      end else begin
         fetch_cnt_q  <= fetch_cnt_d;
         squash_cnt_q <= squash_cnt_d;
      end
   end

   assign fetch_cnt  = fetch_cnt_q;
   assign squash_cnt = squash_cnt_q;
`endif

endmodule
